// File: rtl/door_lock_pkg.sv
// door_lock_pkg
// Shared definitions for the door lock front-end arbiter: key codes that
// terminate a keypad sequence, the arbiter FSM state type and the owner
// encodings reported on the owner port.
// Optional feature macro: DOOR_AUTO_CLOSE_EN adds the CLOSE state.
package door_lock_pkg;

  localparam logic [3:0] KEY_OPEN = 4'd10;
  localparam logic [3:0] KEY_SET  = 4'd11;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    OWN_A,
    OWN_B,
    CHECK
`ifdef DOOR_AUTO_CLOSE_EN
    , CLOSE
`endif
  } arb_state_t;

  // Anything that is not a terminator is treated as a digit by the core.
  function automatic logic is_digit(input logic [3:0] key);
    return (key != KEY_OPEN) && (key != KEY_SET);
  endfunction

endpackage

// File: rtl/door_lock_arbiter_timer.sv
// lock_timer
// Loadable down-counter that stops at zero and flags it. Used by the
// arbiter for the session timeout, the lockout period and the auto-close
// delay.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (count returns to RESET_VAL)
//   load_i     load load_val_i this cycle (wins over counting)
//   load_val_i value to load
//   en_i       decrement this cycle if the count is not already zero
//   zero_o     count is zero
module lock_timer #(
  parameter int             W         = 4,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  // Load has priority; otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/door_lock_arbiter.sv
// door_lock_arbiter
// Shares the door lock core's single key port between an outside keypad (A)
// and an inside keypad (B). A keypad owns the port from its first digit until
// it terminates the sequence or goes quiet for SESS_TO cycles. Open attempts
// are judged two cycles after the OPEN key by watching door_open; MAX_FAIL
// failures lock the outside keypad out for LOCK_CYC cycles. The inside
// keypad is never locked out and a successful open from it lifts a lockout.
// Optional feature macro: DOOR_AUTO_CLOSE_EN -- closes a door left open in
// IDLE for AUTO_CYC cycles by injecting an OPEN/close key.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   a_valid/a_key/a_ready   outside keypad handshake
//   b_valid/b_key/b_ready   inside keypad handshake
//   lk_valid/lk_key         key strobe towards the core
//   door_open               door state from the core
//   lockout, fail_cnt, owner  status
module door_lock_arbiter
  import door_lock_pkg::*;
#(
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYC = 1000,
  parameter int SESS_TO  = 200
`ifdef DOOR_AUTO_CLOSE_EN
  , parameter int AUTO_CYC = 500
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_valid,
  input  logic [3:0] a_key,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [3:0] b_key,
  output logic       b_ready,
  output logic       lk_valid,
  output logic [3:0] lk_key,
  input  logic       door_open,
  output logic       lockout,
  output logic [2:0] fail_cnt,
  output logic [1:0] owner
);

  localparam int         SESS_W   = $clog2(SESS_TO);
  localparam int         LOCK_W   = $clog2(LOCK_CYC);
  localparam logic [2:0] FAIL_MAX = 3'(MAX_FAIL);

  arb_state_t state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic       lk_valid_q, lk_valid_d;
  logic [3:0] lk_key_q, lk_key_d;
  logic       lockout_q, lockout_d;
  logic [2:0] fail_q, fail_d;
  logic       pre_q, pre_d;
  logic       req_b_q, req_b_d;
  logic       chk_q, chk_d;

  logic       a_xfer, b_xfer, xfer;
  logic [3:0] key_in;
  logic       sess_load, sess_zero;
  logic       lock_load, lock_zero;
  logic       idle_hold;

  lock_timer #(.W(SESS_W)) u_sess_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (sess_load),
    .load_val_i (SESS_W'(SESS_TO - 1)),
    .en_i       (1'b1),
    .zero_o     (sess_zero)
  );

  lock_timer #(.W(LOCK_W)) u_lock_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (lock_load),
    .load_val_i (LOCK_W'(LOCK_CYC - 1)),
    .en_i       (1'b1),
    .zero_o     (lock_zero)
  );

`ifdef DOOR_AUTO_CLOSE_EN
  localparam int AUTO_W = $clog2(AUTO_CYC);
  logic auto_armed, auto_zero, auto_fire;

  // The delay counter only runs while idle with the door open; any other
  // cycle reloads it, so leaving IDLE or closing the door restarts it.
  assign auto_armed = (state_q == IDLE) && door_open;

  lock_timer #(.W(AUTO_W), .RESET_VAL(AUTO_W'(AUTO_CYC - 1))) u_auto_timer (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (!auto_armed),
    .load_val_i (AUTO_W'(AUTO_CYC - 1)),
    .en_i       (auto_armed),
    .zero_o     (auto_zero)
  );

  assign auto_fire = auto_armed && auto_zero;
  assign idle_hold = auto_fire;
`else
  assign idle_hold = 1'b0;
`endif

  // Readies are combinational so B can pre-empt A in the very cycle both
  // request an idle port. A only loses when both strobes are present.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (state_q)
      IDLE: begin
        b_ready = !idle_hold;
        a_ready = !idle_hold && !lockout_q && !(a_valid && b_valid);
      end
      OWN_A:   a_ready = 1'b1;
      OWN_B:   b_ready = 1'b1;
      default: ;
    endcase
  end

  assign a_xfer = a_valid && a_ready;
  assign b_xfer = b_valid && b_ready;
  assign xfer   = a_xfer || b_xfer;
  assign key_in = b_xfer ? b_key : a_key;

  // Next-state logic. Lockout expiry is applied first so an attempt judged
  // in the same cycle still sees a consistent count.
  always_comb begin
    state_d    = state_q;
    lk_valid_d = 1'b0;
    lk_key_d   = lk_key_q;
    lockout_d  = lockout_q;
    fail_d     = fail_q;
    pre_d      = pre_q;
    req_b_d    = req_b_q;
    chk_d      = chk_q;
    sess_load  = 1'b0;
    lock_load  = 1'b0;

    if (xfer) begin
      lk_valid_d = 1'b1;
      lk_key_d   = key_in;
    end

    if (lockout_q && lock_zero) begin
      lockout_d = 1'b0;
      fail_d    = 3'd0;
    end

    case (state_q)
      IDLE, OWN_A, OWN_B: begin
        if (xfer) begin
          if (key_in == KEY_OPEN) begin
            state_d = CHECK;
            pre_d   = door_open;
            req_b_d = b_xfer;
            chk_d   = 1'b0;
          end else if (is_digit(key_in)) begin
            sess_load = 1'b1;
            if (state_q == IDLE) begin
              state_d = b_xfer ? OWN_B : OWN_A;
            end
          end else if (state_q != IDLE) begin
            state_d = IDLE;
          end
        end else if ((state_q != IDLE) && sess_zero) begin
          state_d = IDLE;
        end
      end

      // Second CHECK cycle: door_open now reflects the core's verdict.
      CHECK: begin
        chk_d = 1'b1;
        if (chk_q) begin
          state_d = IDLE;
          chk_d   = 1'b0;
          if (!pre_q) begin
            if (door_open) begin
              fail_d = 3'd0;
              if (req_b_q) begin
                lockout_d = 1'b0;
              end
            end else if (fail_q < FAIL_MAX) begin
              fail_d = fail_q + 3'd1;
              if ((fail_q + 3'd1) == FAIL_MAX) begin
                lockout_d = 1'b1;
                lock_load = 1'b1;
              end
            end
          end
        end
      end

`ifdef DOOR_AUTO_CLOSE_EN
      // Inject the close key and judge it like a door-close request.
      CLOSE: begin
        lk_valid_d = 1'b1;
        lk_key_d   = KEY_OPEN;
        state_d    = CHECK;
        pre_d      = 1'b1;
        req_b_d    = 1'b0;
        chk_d      = 1'b0;
      end
`endif

      default: state_d = IDLE;
    endcase

`ifdef DOOR_AUTO_CLOSE_EN
    if (auto_fire) begin
      state_d = CLOSE;
    end
`endif

    case (state_d)
      OWN_A:   owner_d = OWNER_A;
      OWN_B:   owner_d = OWNER_B;
      default: owner_d = OWNER_NONE;
    endcase
  end

  // All FSM state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= OWNER_NONE;
      lk_valid_q <= 1'b0;
      lk_key_q   <= 4'd0;
      lockout_q  <= 1'b0;
      fail_q     <= 3'd0;
      pre_q      <= 1'b0;
      req_b_q    <= 1'b0;
      chk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lk_valid_q <= lk_valid_d;
      lk_key_q   <= lk_key_d;
      lockout_q  <= lockout_d;
      fail_q     <= fail_d;
      pre_q      <= pre_d;
      req_b_q    <= req_b_d;
      chk_q      <= chk_d;
    end
  end

  assign lk_valid = lk_valid_q;
  assign lk_key   = lk_key_q;
  assign lockout  = lockout_q;
  assign fail_cnt = fail_q;
  assign owner    = owner_q;

endmodule

// File: tb/tb_door_lock_arbiter.sv
// tb_door_lock_arbiter
// Self-checking bench for door_lock_arbiter with a small behavioural model of
// the lock core (code 2490). Forwarded keys are checked through a queue of
// expected keys; status outputs are checked at fixed cycle offsets.
// Optional feature macro: DOOR_AUTO_CLOSE_EN selects the auto-close scenario.
module tb_door_lock_arbiter;
  import door_lock_pkg::*;

  localparam int LOCK = 1000;
  localparam int SESS = 200;
`ifdef DOOR_AUTO_CLOSE_EN
  localparam int AUTO = 20;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       a_valid = 1'b0;
  logic [3:0] a_key = 4'd0;
  logic       a_ready;
  logic       b_valid = 1'b0;
  logic [3:0] b_key = 4'd0;
  logic       b_ready;
  logic       lk_valid;
  logic [3:0] lk_key;
  logic       door_open = 1'b0;
  logic       lockout;
  logic [2:0] fail_cnt;
  logic [1:0] owner;

  int         nChecks = 0;
  int         nFails = 0;
  logic [3:0] expLk[$];
  logic [3:0] expHead;
  logic [15:0] coreBuf = 16'hFFFF;

  typedef struct {
    logic aV;
    logic bV;
    logic expAR;
    logic expBR;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  door_lock_arbiter #(
    .MAX_FAIL (3),
    .LOCK_CYC (LOCK),
    .SESS_TO  (SESS)
`ifdef DOOR_AUTO_CLOSE_EN
    , .AUTO_CYC (AUTO)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_key     (a_key),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_key     (b_key),
    .b_ready   (b_ready),
    .lk_valid  (lk_valid),
    .lk_key    (lk_key),
    .door_open (door_open),
    .lockout   (lockout),
    .fail_cnt  (fail_cnt),
    .owner     (owner)
  );

  // Behavioural lock core: keeps the last four digits, opens on the right
  // code, closes on any OPEN key while open. Not cleared by the arbiter reset.
  always @(posedge clk) begin
    if (lk_valid === 1'b1) begin
      if (lk_key == KEY_OPEN) begin
        if (door_open) door_open <= 1'b0;
        else if (coreBuf == 16'h2490) door_open <= 1'b1;
        coreBuf <= 16'hFFFF;
      end else if (lk_key == KEY_SET) begin
        coreBuf <= 16'hFFFF;
      end else begin
        coreBuf <= {coreBuf[11:0], lk_key};
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard: every strobe towards the core must match the next expected key.
  always @(negedge clk) begin
    if (reset && (lk_valid === 1'b1)) begin
      if (expLk.size() == 0) begin
        checkOutput("lk_unexpected", 32'd1, 32'd0);
      end else begin
        expHead = expLk.pop_front();
        checkOutput("lk_key", {28'd0, lk_key}, {28'd0, expHead});
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one key from a keypad, expect it accepted, and check the other
  // keypad's ready in that cycle. Returns 1 time unit after the transfer edge.
  task automatic applyStimulus(input bit useB, input logic [3:0] k, input bit expOther);
    if (useB) begin b_valid = 1'b1; b_key = k; end
    else      begin a_valid = 1'b1; a_key = k; end
    @(negedge clk);
    if (useB) begin
      checkOutput("b_ready_own", {31'd0, b_ready}, 32'd1);
      checkOutput("a_ready_other", {31'd0, a_ready}, {31'd0, expOther});
    end else begin
      checkOutput("a_ready_own", {31'd0, a_ready}, 32'd1);
      checkOutput("b_ready_other", {31'd0, b_ready}, {31'd0, expOther});
    end
    expLk.push_back(k);
    @(posedge clk);
    #1;
    if (useB) b_valid = 1'b0;
    else      a_valid = 1'b0;
  endtask

  // Four digits then OPEN, then wait until the attempt has been judged.
  task automatic enterCode(input bit useB, input logic [15:0] code, input bit otherIdle);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(useB, code[15-4*i -: 4], (i == 0) ? otherIdle : 1'b0);
    end
    applyStimulus(useB, KEY_OPEN, 1'b0);
    waitCycles(2);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{aV: 1'b0, bV: 1'b0, expAR: 1'b1, expBR: 1'b1};
    vecs[1] = '{aV: 1'b1, bV: 1'b0, expAR: 1'b1, expBR: 1'b1};
    vecs[2] = '{aV: 1'b0, bV: 1'b1, expAR: 1'b1, expBR: 1'b1};
    vecs[3] = '{aV: 1'b1, bV: 1'b1, expAR: 1'b0, expBR: 1'b1};

    // Reset state and idle ready arbitration, applied while reset is held.
    a_key = 4'd5;
    b_key = 4'd7;
    for (int i = 0; i < 4; i++) begin
      a_valid = vecs[i].aV;
      b_valid = vecs[i].bV;
      @(negedge clk);
      checkOutput("rst_a_ready", {31'd0, a_ready}, {31'd0, vecs[i].expAR});
      checkOutput("rst_b_ready", {31'd0, b_ready}, {31'd0, vecs[i].expBR});
      checkOutput("rst_lk_valid", {31'd0, lk_valid}, 32'd0);
      checkOutput("rst_lk_key", {28'd0, lk_key}, 32'd0);
      checkOutput("rst_lockout", {31'd0, lockout}, 32'd0);
      checkOutput("rst_fail_cnt", {29'd0, fail_cnt}, 32'd0);
      checkOutput("rst_owner", {30'd0, owner}, 32'd0);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    waitCycles(1);

    // Ownership: A holds the port while B keeps requesting.
    applyStimulus(1'b0, 4'd2, 1'b1);
    checkOutput("own_owner_a", {30'd0, owner}, {30'd0, OWNER_A});
    b_valid = 1'b1;
    b_key   = 4'd7;
    applyStimulus(1'b0, 4'd4, 1'b0);
    applyStimulus(1'b0, 4'd9, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, KEY_OPEN, 1'b0);
    b_valid = 1'b0;
    checkOutput("chk_a_ready", {31'd0, a_ready}, 32'd0);
    checkOutput("chk_b_ready", {31'd0, b_ready}, 32'd0);
    checkOutput("chk_owner", {30'd0, owner}, 32'd0);
    waitCycles(1);
    checkOutput("chk2_b_ready", {31'd0, b_ready}, 32'd0);
    waitCycles(1);
    checkOutput("open_fail_cnt", {29'd0, fail_cnt}, 32'd0);
    checkOutput("open_owner", {30'd0, owner}, 32'd0);
    checkOutput("open_a_ready", {31'd0, a_ready}, 32'd1);
    checkOutput("lk_valid_idle", {31'd0, lk_valid}, 32'd0);
    checkOutput("lk_key_hold", {28'd0, lk_key}, {28'd0, KEY_OPEN});

    // Simultaneous idle requests: B wins, A is held off combinationally.
    a_valid = 1'b1; a_key = 4'd5;
    b_valid = 1'b1; b_key = 4'd7;
    @(negedge clk);
    checkOutput("sim_a_ready", {31'd0, a_ready}, 32'd0);
    checkOutput("sim_b_ready", {31'd0, b_ready}, 32'd1);
    expLk.push_back(4'd7);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    checkOutput("sim_owner_b", {30'd0, owner}, {30'd0, OWNER_B});

    // Session timeout after B's last digit.
    applyStimulus(1'b1, 4'd3, 1'b0);
    waitCycles(SESS - 1);
    checkOutput("sess_owner_hold", {30'd0, owner}, {30'd0, OWNER_B});
    waitCycles(1);
    checkOutput("sess_owner_free", {30'd0, owner}, 32'd0);
    checkOutput("sess_a_ready", {31'd0, a_ready}, 32'd1);
    applyStimulus(1'b0, KEY_OPEN, 1'b1);
    waitCycles(2);
    checkOutput("close_fail_cnt", {29'd0, fail_cnt}, 32'd0);

    // Lockout after three wrong codes from outside, then timed expiry.
    for (int r = 1; r <= 3; r++) begin
      enterCode(1'b0, 16'h1111, 1'b1);
      checkOutput("lo_fail_cnt", {29'd0, fail_cnt}, r);
      checkOutput("lo_lockout", {31'd0, lockout}, (r == 3) ? 32'd1 : 32'd0);
    end
    checkOutput("lo_a_ready", {31'd0, a_ready}, 32'd0);
    a_valid = 1'b1;
    a_key   = 4'd5;
    @(negedge clk);
    checkOutput("lo_a_blocked", {31'd0, a_ready}, 32'd0);
    checkOutput("lo_b_ready", {31'd0, b_ready}, 32'd1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    waitCycles(LOCK - 2);
    checkOutput("lo_still_locked", {31'd0, lockout}, 32'd1);
    waitCycles(1);
    checkOutput("lo_expired", {31'd0, lockout}, 32'd0);
    checkOutput("lo_fail_cleared", {29'd0, fail_cnt}, 32'd0);
    checkOutput("lo_a_ready_back", {31'd0, a_ready}, 32'd1);

    // Inside override during a fresh lockout; B failures saturate the count.
    for (int r = 1; r <= 3; r++) enterCode(1'b0, 16'h1111, 1'b1);
    checkOutput("ov_lockout", {31'd0, lockout}, 32'd1);
    enterCode(1'b1, 16'h1111, 1'b0);
    checkOutput("ov_fail_sat", {29'd0, fail_cnt}, 32'd3);
    checkOutput("ov_lock_kept", {31'd0, lockout}, 32'd1);
    enterCode(1'b1, 16'h2490, 1'b0);
    checkOutput("ov_lock_clear", {31'd0, lockout}, 32'd0);
    checkOutput("ov_fail_clear", {29'd0, fail_cnt}, 32'd0);
    checkOutput("ov_a_ready", {31'd0, a_ready}, 32'd1);

`ifdef DOOR_AUTO_CLOSE_EN
    // Door left open in IDLE: close key injected after AUTO cycles.
    waitCycles(AUTO - 2);
    checkOutput("ac_b_ready_pre", {31'd0, b_ready}, 32'd1);
    waitCycles(1);
    checkOutput("ac_a_ready_fire", {31'd0, a_ready}, 32'd0);
    checkOutput("ac_b_ready_fire", {31'd0, b_ready}, 32'd0);
    expLk.push_back(KEY_OPEN);
    waitCycles(1);
    checkOutput("ac_lk_quiet", {31'd0, lk_valid}, 32'd0);
    waitCycles(1);
    checkOutput("ac_lk_valid", {31'd0, lk_valid}, 32'd1);
    checkOutput("ac_lk_key", {28'd0, lk_key}, {28'd0, KEY_OPEN});
    waitCycles(2);
    checkOutput("ac_fail_cnt", {29'd0, fail_cnt}, 32'd0);
    checkOutput("ac_a_ready", {31'd0, a_ready}, 32'd1);
`else
    // Without auto-close nothing is injected while the door stays open.
    waitCycles(30);
    checkOutput("nac_lk_valid", {31'd0, lk_valid}, 32'd0);
    checkOutput("nac_b_ready", {31'd0, b_ready}, 32'd1);
    applyStimulus(1'b1, KEY_OPEN, 1'b1);
    waitCycles(2);
`endif

    // Reset in the middle of a session clears count and ownership.
    enterCode(1'b0, 16'h1357, 1'b1);
    checkOutput("mr_fail_one", {29'd0, fail_cnt}, 32'd1);
    applyStimulus(1'b0, 4'd2, 1'b1);
    checkOutput("mr_owner_a", {30'd0, owner}, {30'd0, OWNER_A});
    waitCycles(1);
    reset = 1'b0;
    #1;
    checkOutput("mr_owner", {30'd0, owner}, 32'd0);
    checkOutput("mr_fail_cnt", {29'd0, fail_cnt}, 32'd0);
    checkOutput("mr_lk_valid", {31'd0, lk_valid}, 32'd0);
    checkOutput("mr_a_ready", {31'd0, a_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    waitCycles(3);
    checkOutput("lk_queue_empty", expLk.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
